// File: rtl/csi2_rx_pkg.sv
// Shared types and constants for the CSI-2 receive-side pixel path.
package csi2_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SOF,
        FWD
    } arb_state_t;

    localparam int unsigned PX_PER_WORD = 4;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
    parameter int unsigned TDATA_WIDTH = 40,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 4,
    parameter int unsigned TDEST_WIDTH = 4
);
    localparam int unsigned TSTRB_WIDTH = (TDATA_WIDTH + 7) / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TSTRB_WIDTH-1:0] tstrb;
    logic [TSTRB_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );

endinterface

// File: rtl/csi2_rr_picker.sv
// Combinational round-robin finder: first set request at or above ptr_i, wrapping.
module csi2_rr_picker #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int unsigned cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        // Scan from the farthest offset down so the nearest request is written last.
        for (int unsigned ofs = N; ofs > 0; ofs--) begin
            cand = 32'(ptr_i) + ofs - 1;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req_i[cand[IW-1:0]]) begin
                idx_o   = cand[IW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csi2_vc_arbiter.sv
// Packet-granular round-robin arbiter feeding one pixel serializer from VC_CNT streams;
// drains the serializer and pulses its frame start ahead of a VC with a pending SOF.
module csi2_vc_arbiter
    import csi2_rx_pkg::*;
#(
    parameter  int unsigned VC_CNT      = 4,
    parameter  int unsigned TDATA_WIDTH = 40,
    localparam int unsigned VC_W        = $clog2(VC_CNT)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [VC_CNT-1:0]             frame_start_i,
    input  logic [VC_CNT-1:0]             pkt_tvalid_i,
    input  logic [VC_CNT*TDATA_WIDTH-1:0] pkt_tdata_i,
    input  logic [VC_CNT-1:0]             pkt_tlast_i,
    output logic [VC_CNT-1:0]             pkt_tready_o,
    axi4_stream_if.master                 pkt_o,
    output logic                          frame_start_o,
    input  logic                          px_hs_i,
    output logic [VC_W-1:0]               vc_o
);

    arb_state_t        state_q, state_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [VC_CNT-1:0] sof_pend_q, sof_pend_d;
    logic [2:0]        px_cnt_q, px_cnt_d;

    logic [VC_W-1:0]        pick_idx;
    logic                   pick_found;
    logic [TDATA_WIDTH-1:0] sel_tdata;
    logic                   sel_tvalid;
    logic                   sel_tlast;
    logic                   fwd;
    logic                   out_hs;
    logic [VC_CNT-1:0]      sof_clr;
    logic [4:0]             px_wide;
    logic                   px_err;

    csi2_rr_picker #(
        .N (VC_CNT)
    ) u_picker (
        .req_i   (pkt_tvalid_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        sel_tdata  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int unsigned k = 0; k < VC_CNT; k++) begin
            if (vc_q == VC_W'(k)) begin
                sel_tdata  = pkt_tdata_i[k*TDATA_WIDTH +: TDATA_WIDTH];
                sel_tvalid = pkt_tvalid_i[k];
                sel_tlast  = pkt_tlast_i[k];
            end
        end
    end

    assign fwd           = (state_q == FWD);
    assign pkt_o.tvalid  = fwd && sel_tvalid;
    assign pkt_o.tdata   = sel_tdata;
    assign pkt_o.tlast   = sel_tlast;
    assign pkt_o.tuser   = '0;
    assign pkt_o.tstrb   = '1;
    assign pkt_o.tkeep   = '1;
    assign pkt_o.tid     = '0;
    assign pkt_o.tdest   = '0;
    assign out_hs        = pkt_o.tvalid && pkt_o.tready;
    assign frame_start_o = (state_q == SOF);
    assign vc_o          = vc_q;

    always_comb begin
        pkt_tready_o = '0;
        for (int unsigned k = 0; k < VC_CNT; k++) begin
            pkt_tready_o[k] = fwd && (vc_q == VC_W'(k)) && pkt_o.tready;
        end
    end

    always_comb begin
        state_d  = state_q;
        vc_d     = vc_q;
        rr_ptr_d = rr_ptr_q;
        sof_clr  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    vc_d    = pick_idx;
                    state_d = sof_pend_q[pick_idx] ? DRAIN : FWD;
                end
            end
            DRAIN: begin
                if (px_cnt_q == 3'd0) begin
                    state_d = SOF;
                end
            end
            SOF: begin
                sof_clr = VC_CNT'(1) << vc_q;
                state_d = FWD;
            end
            FWD: begin
                if (out_hs && sel_tlast) begin
                    rr_ptr_d = (vc_q == VC_W'(VC_CNT - 1)) ? '0 : vc_q + VC_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new frame start wins over the clear from the SOF being issued this cycle.
    assign sof_pend_d = (sof_pend_q & ~sof_clr) | frame_start_i;

    always_comb begin
        px_wide  = {2'b00, px_cnt_q} + (out_hs ? 5'(PX_PER_WORD) : 5'd0) - {4'd0, px_hs_i};
        px_cnt_d = px_wide[2:0];
        px_err   = |px_wide[4:3];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            vc_q       <= '0;
            rr_ptr_q   <= '0;
            sof_pend_q <= '0;
            px_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            vc_q       <= vc_d;
            rr_ptr_q   <= rr_ptr_d;
            sof_pend_q <= sof_pend_d;
            px_cnt_q   <= px_cnt_d;
        end
    end

    px_cnt_range_a: assert property (@(posedge clk_i) disable iff (!rst_n_i) !px_err);

endmodule

// File: tb/tb_csi2_vc_arbiter.sv
// Randomized bench for csi2_vc_arbiter against a cycle-level reference of the arbitration rules.
module tb_csi2_vc_arbiter;

    localparam int unsigned VC_CNT = 4;
    localparam int unsigned TDW    = 40;
    localparam int unsigned VC_W   = 2;

    logic                  clk    = 1'b0;
    logic                  rst_n  = 1'b1;
    logic [VC_CNT-1:0]     fs_in  = '0;
    logic [VC_CNT-1:0]     tvalid = '0;
    logic [VC_CNT-1:0]     tlast  = '0;
    logic [VC_CNT*TDW-1:0] tdata  = '0;
    logic                  px_hs  = 1'b0;
    logic [VC_CNT-1:0]     tready_o;
    logic                  fs_out;
    logic [VC_W-1:0]       vc_out;

    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(TDW)) pkt_if ();

    csi2_vc_arbiter #(
        .VC_CNT      (VC_CNT),
        .TDATA_WIDTH (TDW)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .frame_start_i (fs_in),
        .pkt_tvalid_i  (tvalid),
        .pkt_tdata_i   (tdata),
        .pkt_tlast_i   (tlast),
        .pkt_tready_o  (tready_o),
        .pkt_o         (pkt_if),
        .frame_start_o (fs_out),
        .px_hs_i       (px_hs),
        .vc_o          (vc_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference: owner/phase view (phase 0 forward, 1 waiting for serializer empty, 2 SOF pulse).
    bit              m_busy;
    int              m_vc, m_phase, m_ptr, m_px;
    bit [VC_CNT-1:0] m_pend;

    int              src_rem [VC_CNT];
    int              src_len [VC_CNT];
    bit              src_first [VC_CNT];
    bit              src_en [VC_CNT];
    logic [TDW-1:0]  src_word [VC_CNT];

    int fixed_len, ready_mode, drop_pct, fs_pct, scen;
    int fs_count, last_fs_cyc, last_tlast_cyc, cur_vc, words_in_pkt;
    int first_cyc [VC_CNT];
    int grants [$];
    bit s3_done, s5_b;
    int s5_t0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [TDW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[TDW-1:0];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_vc = 0; m_phase = 0; m_ptr = 0; m_px = 0; m_pend = '0;
        for (int k = 0; k < VC_CNT; k++) begin
            src_rem[k] = 0; src_first[k] = 0; first_cyc[k] = -1;
        end
        fs_count = 0; last_fs_cyc = -1; last_tlast_cyc = -1;
        cur_vc = 0; words_in_pkt = 0; s3_done = 0; s5_b = 0;
        grants.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tvalid = '0; tlast = '0; fs_in = '0; px_hs = 1'b0; pkt_if.tready = 1'b0;
        #1;
        check_eq("rst_tvalid", pkt_if.tvalid, 0);
        check_eq("rst_tready_o", tready_o, 0);
        check_eq("rst_frame_start", fs_out, 0);
        check_eq("rst_vc_o", vc_out, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive();
        bit want;
        for (int k = 0; k < VC_CNT; k++) begin
            if (src_en[k] && src_rem[k] == 0) begin
                src_len[k]   = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
                src_rem[k]   = src_len[k];
                src_first[k] = 1;
                src_word[k]  = rand_word();
            end
            tvalid[k] = (src_rem[k] > 0) && !(drop_pct > 0 && int'($urandom_range(0, 99)) < drop_pct);
            tlast[k]  = (src_rem[k] == 1);
            tdata[k*TDW +: TDW] = src_word[k];
            fs_in[k]  = (fs_pct > 0) && int'($urandom_range(0, 99)) < fs_pct;
        end
        if (scen == 3 && !s3_done && m_busy && m_phase == 0 && m_vc == 1) begin
            fs_in[2] = 1'b1;
            s3_done  = 1;
        end
        if (scen == 5) begin
            if (cyc == s5_t0 + 3) fs_in[1] = 1'b1;
            if (!s5_b && m_busy && m_phase == 2 && m_vc == 1) begin
                fs_in[1] = 1'b1;
                s5_b     = 1;
            end
        end
        case (ready_mode)
            1:       want = (cyc % 2) == 0;
            2:       want = $urandom_range(0, 3) != 0;
            default: want = 1'b1;
        endcase
        // The serializer model eats one pixel per cycle; never offer a word that would overflow it.
        pkt_if.tready = want && (m_px <= 4);
        px_hs = (m_px > 0);
    endtask

    task automatic check_step();
        bit              fwd, fs_exp, e_tv, hs, obs_hs, found;
        logic [VC_CNT-1:0] e_rdy;
        int              px_old, k;
        bit [VC_CNT-1:0] pend_old;

        fwd    = m_busy && m_phase == 0;
        fs_exp = m_busy && m_phase == 2;
        e_tv   = fwd && tvalid[m_vc];
        e_rdy  = '0;
        if (fwd && pkt_if.tready) e_rdy[m_vc] = 1'b1;

        check_eq("vc_o", vc_out, m_vc);
        check_eq("frame_start_o", fs_out, fs_exp);
        check_eq("tvalid", pkt_if.tvalid, e_tv);
        check_eq("tready_o", tready_o, e_rdy);
        if (e_tv) begin
            check_eq("tdata", pkt_if.tdata, src_word[m_vc]);
            check_eq("tlast", pkt_if.tlast, src_rem[m_vc] == 1);
        end
        hs = e_tv && pkt_if.tready;

        if (fs_out === 1'b1) begin
            fs_count++;
            last_fs_cyc = cyc;
        end
        obs_hs = (pkt_if.tvalid === 1'b1) && pkt_if.tready;
        if (obs_hs) begin
            if (words_in_pkt == 0) begin
                grants.push_back(int'(vc_out));
                cur_vc = int'(vc_out);
                if (first_cyc[vc_out] < 0) first_cyc[vc_out] = cyc;
                if (last_tlast_cyc >= 0) check_eq("gap", (cyc - last_tlast_cyc) >= 2, 1);
            end else begin
                check_eq("no_interleave", vc_out, cur_vc);
            end
            words_in_pkt++;
            if (pkt_if.tlast === 1'b1) begin
                check_eq("pkt_len", words_in_pkt, src_len[vc_out]);
                last_tlast_cyc = cyc;
                words_in_pkt   = 0;
            end
        end
        for (int j = 0; j < VC_CNT; j++) begin
            if (tvalid[j] && tready_o[j] === 1'b1) begin
                src_rem[j]--;
                src_first[j] = 0;
                src_word[j]  = rand_word();
            end
        end

        px_old   = m_px;
        pend_old = m_pend;
        m_px     = m_px + (hs ? 4 : 0) - (px_hs ? 1 : 0);
        if (fs_exp) m_pend[m_vc] = 1'b0;
        m_pend = m_pend | fs_in;
        if (!m_busy) begin
            found = 0;
            for (int i = 0; i < VC_CNT; i++) begin
                k = (m_ptr + i) % VC_CNT;
                if (!found && tvalid[k]) begin
                    found   = 1;
                    m_vc    = k;
                    m_busy  = 1;
                    m_phase = pend_old[k] ? 1 : 0;
                end
            end
        end else if (m_phase == 1) begin
            if (px_old == 0) m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (hs && tlast[m_vc]) begin
            m_ptr  = (m_vc + 1) % VC_CNT;
            m_busy = 0;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            @(negedge clk);
            check_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_src(input bit [VC_CNT-1:0] en, input int len, input int rdy, input int drop, input int fsp);
        for (int k = 0; k < VC_CNT; k++) src_en[k] = en[k];
        fixed_len = len; ready_mode = rdy; drop_pct = drop; fs_pct = fsp;
    endtask

    initial begin
        int waited;
        scen = 0;
        set_src(4'b0000, 0, 0, 0, 0);
        #1;
        do_reset();
        check_eq("tkeep", pkt_if.tkeep, 64'h1f);
        check_eq("tstrb", pkt_if.tstrb, 64'h1f);
        check_eq("tuser", pkt_if.tuser, 0);
        check_eq("tid", pkt_if.tid, 0);
        check_eq("tdest", pkt_if.tdest, 0);

        // VC0 alone, 3-word packets, no frame start.
        scen = 1; set_src(4'b0001, 3, 0, 0, 0);
        run(40);
        check_eq("s1_fs_count", fs_count, 0);
        check_eq("s1_grant_cnt", grants.size() >= 2, 1);
        foreach (grants[i]) check_eq("s1_grant_vc", grants[i], 0);

        // All VCs busy with 2-word packets: strict rotation.
        do_reset();
        scen = 2; set_src(4'b1111, 2, 0, 0, 0);
        run(80);
        check_eq("s2_grant_cnt", grants.size() >= 8, 1);
        if (grants.size() >= 8)
            for (int i = 0; i < 8; i++) check_eq("s2_order", grants[i], i % 4);

        // Frame start on VC2 while VC1 forwards.
        do_reset();
        scen = 3; set_src(4'b0110, 2, 0, 0, 0);
        run(60);
        check_eq("s3_fs_count", fs_count, 1);
        check_eq("s3_first_grants", (grants.size() >= 2) ? {grants[0][3:0], grants[1][3:0]} : 8'hff, 8'h12);
        check_eq("s3_sof_to_word", first_cyc[2] - last_fs_cyc, 1);

        // Downstream ready toggling on 4-word packets.
        do_reset();
        scen = 4; set_src(4'b1000, 4, 1, 0, 0);
        run(60);
        check_eq("s4_grant_cnt", grants.size() >= 2, 1);
        check_eq("s4_fs_count", fs_count, 0);

        // Frame start on VC1 in the very cycle its SOF is issued.
        do_reset();
        scen = 5; s5_t0 = cyc; set_src(4'b0010, 1, 0, 0, 0);
        run(60);
        check_eq("s5_same_cycle_hit", s5_b, 1);
        check_eq("s5_fs_count", fs_count, 2);

        // Random traffic.
        do_reset();
        scen = 6;
        for (int e = 0; e < 10; e++) begin
            set_src(4'($urandom_range(1, 15)), 0, 2, 15, 4);
            run(300);
        end
        check_eq("s6_traffic", grants.size() > 20, 1);

        // Asynchronous reset in the middle of a forwarded packet.
        do_reset();
        scen = 7; set_src(4'b1111, 4, 0, 0, 0);
        waited = 0;
        while (!(m_busy && m_phase == 0) && waited < 50) begin
            run(1);
            waited++;
        end
        check_eq("s7_reach_fwd", m_busy && m_phase == 0, 1);
        drive();
        #1;
        check_eq("s7_pre_tvalid", pkt_if.tvalid, 1);
        #1;
        do_reset();
        run(30);
        check_eq("s7_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
